// File: rtl/ahb_bus_arbiter.sv
// ============================================================================
// Module      : ahb_bus_arbiter
// Description : AHB round-robin bus arbiter with burst-aware handover points,
//               registered one-hot grant and address/data-phase owner indices.
//               Locked transfers are supported when AHB_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_W      = 3
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MIDX_W-1:0]      HMASTER,
    output logic [MIDX_W-1:0]      HMASTERD
);

    localparam logic [1:0] c_trans_idle   = 2'b00;
    localparam logic [1:0] c_trans_nonseq = 2'b10;
    localparam logic [1:0] c_trans_seq    = 2'b11;

    localparam logic [2:0] c_burst_single = 3'b000;
    localparam logic [2:0] c_burst_incr   = 3'b001;

    localparam logic [NUM_MASTERS-1:0] c_grant_m0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [MIDX_W-1:0]      r_hmaster;
    logic [MIDX_W-1:0]      r_hmasterd;
    logic [3:0]             r_cnt;
    logic                   r_incr_open;

    logic [3:0]             w_cnt_nxt;
    logic                   w_incr_nxt;
    logic                   w_arb_point;
    logic                   w_accept_idle;
    logic                   w_accept_nonseq;
    logic                   w_lock_nxt;
    logic                   w_rr_found;
    logic [MIDX_W-1:0]      w_rr_winner;
    logic [MIDX_W-1:0]      w_winner;
    logic [NUM_MASTERS-1:0] w_grant_nxt;

    assign w_accept_idle   = HREADY && (HTRANS == c_trans_idle);
    assign w_accept_nonseq = HREADY && (HTRANS == c_trans_nonseq);

    // The arbitration test uses the counter value before this cycle's update,
    // so a SEQ seen with one beat remaining is the last beat of the burst.
    assign w_arb_point = HREADY &&
                         ((HTRANS == c_trans_idle) ||
                          ((HTRANS == c_trans_nonseq) && (HBURST == c_burst_single)) ||
                          ((HTRANS == c_trans_seq) && (r_cnt == 4'd1) && !r_incr_open));

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_incr_nxt = r_incr_open;
        if (HREADY) begin
            case (HTRANS)
                c_trans_idle: begin
                    w_incr_nxt = 1'b0;
                end
                c_trans_nonseq: begin
                    w_incr_nxt = 1'b0;
                    w_cnt_nxt  = 4'd0;
                    case (HBURST)
                        c_burst_incr:  w_incr_nxt = 1'b1;
                        3'b010, 3'b011: w_cnt_nxt = 4'd3;
                        3'b100, 3'b101: w_cnt_nxt = 4'd7;
                        3'b110, 3'b111: w_cnt_nxt = 4'd15;
                        default:        w_cnt_nxt = 4'd0;
                    endcase
                end
                c_trans_seq: begin
                    if (r_cnt != 4'd0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_cnt_nxt  = r_cnt;
                    w_incr_nxt = r_incr_open;
                end
            endcase
        end
    end

`ifdef AHB_ARB_LOCK_EN
    logic r_lock;
    logic w_owner_lock;

    // Grant is one-hot and tracks HMASTER, so it selects the owner's HLOCK bit.
    assign w_owner_lock = |(HLOCK & r_hgrant);

    // The lock sampled with this cycle's NONSEQ already protects that transfer.
    always_comb begin
        w_lock_nxt = r_lock;
        if (w_accept_nonseq) begin
            w_lock_nxt = w_owner_lock;
        end else if (w_accept_idle && !w_owner_lock) begin
            w_lock_nxt = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_lock <= 1'b0;
        end else begin
            r_lock <= w_lock_nxt;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = ^{HLOCK, w_accept_nonseq, w_accept_idle};
    assign w_lock_nxt    = 1'b0;
`endif

    // Round-robin search: masters above the current owner first, then wrap to
    // the low indices; the owner itself is reached last.
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!w_rr_found && HBUSREQ[j] && (MIDX_W'(j) > r_hmaster)) begin
                w_rr_found  = 1'b1;
                w_rr_winner = MIDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!w_rr_found && HBUSREQ[j] && (MIDX_W'(j) <= r_hmaster)) begin
                w_rr_found  = 1'b1;
                w_rr_winner = MIDX_W'(j);
            end
        end
    end

    assign w_winner = w_lock_nxt ? r_hmaster : w_rr_winner;

    always_comb begin
        w_grant_nxt = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            w_grant_nxt[j] = (MIDX_W'(j) == w_winner);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hgrant    <= c_grant_m0;
            r_hmaster   <= '0;
            r_hmasterd  <= '0;
            r_cnt       <= 4'd0;
            r_incr_open <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_incr_open <= w_incr_nxt;
            if (HREADY) begin
                r_hmasterd <= r_hmaster;
            end
            if (w_arb_point) begin
                r_hgrant  <= w_grant_nxt;
                r_hmaster <= w_winner;
            end
        end
    end

    assign HGRANT   = r_hgrant;
    assign HMASTER  = r_hmaster;
    assign HMASTERD = r_hmasterd;

endmodule

`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
// ============================================================================
// Module      : tb_ahb_bus_arbiter
// Description : Scoreboard bench for ahb_bus_arbiter: directed handover cases
//               followed by randomized burst traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_bus_arbiter;

    localparam int N  = 4;
    localparam int MW = 3;

`ifdef AHB_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [N-1:0]  HBUSREQ;
    logic [N-1:0]  HLOCK;
    logic [1:0]    HTRANS;
    logic [2:0]    HBURST;
    logic          HREADY;
    logic [N-1:0]  HGRANT;
    logic [MW-1:0] HMASTER;
    logic [MW-1:0] HMASTERD;

    ahb_bus_arbiter #(.NUM_MASTERS(N), .MIDX_W(MW)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTERD (HMASTERD)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [N-1:0] g;
        int           m;
        int           md;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   armed    = 1'b0;

    // Reference state, transaction-level view.
    int m_owner = 0;
    int m_d     = 0;
    int m_cnt   = 0;
    bit m_incr  = 1'b0;
    bit m_lock  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int beats_left(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 3;
            3'd4, 3'd5: return 7;
            3'd6, 3'd7: return 15;
            default:    return 0;
        endcase
    endfunction

    function automatic int pick(input int owner, input logic [N-1:0] req);
        logic [N-1:0] t;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (owner + k) % N;
            t = req >> c;
            if (t[0]) return c;
        end
        return 0;
    endfunction

    task automatic model_step();
        exp_t e;
        if (!HRESETn) begin
            m_owner = 0; m_d = 0; m_cnt = 0; m_incr = 1'b0; m_lock = 1'b0;
            exp_q.delete();
        end else if (HREADY) begin
            bit           arb;
            bit           olock;
            logic [N-1:0] t;
            t     = HLOCK >> m_owner;
            olock = t[0];
            arb   = (HTRANS == IDLE) ||
                    (HTRANS == NONSEQ && HBURST == 3'b000) ||
                    (HTRANS == SEQ && m_cnt == 1 && !m_incr);
            if (LOCK_EN) begin
                if (HTRANS == NONSEQ) m_lock = olock;
                else if (HTRANS == IDLE && !olock) m_lock = 1'b0;
            end
            if (HTRANS == IDLE) begin
                m_incr = 1'b0;
            end else if (HTRANS == NONSEQ) begin
                m_incr = (HBURST == 3'b001);
                m_cnt  = beats_left(HBURST);
            end else if (HTRANS == SEQ && m_cnt > 0) begin
                m_cnt = m_cnt - 1;
            end
            m_d = m_owner;
            if (arb && !m_lock) m_owner = pick(m_owner, HBUSREQ);
        end
        e.g = '0;
        e.g[m_owner] = 1'b1;
        e.m  = m_owner;
        e.md = m_d;
        exp_q.push_back(e);
        armed = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge HCLK or negedge HRESETn);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge HCLK);
            if (armed) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got 0 entries expected 1 at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_hgrant",   int'(HGRANT),   int'(mon_e.g));
                    check("sb_hmaster",  int'(HMASTER),  mon_e.m);
                    check("sb_hmasterd", int'(HMASTERD), mon_e.md);
                    check("sb_onehot",   int'($onehot(HGRANT)), 1);
                end
            end
        end
    end

    task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        HBUSREQ = req; HLOCK = lk; HTRANS = tr; HBURST = bu; HREADY = rdy;
        @(posedge HCLK);
        #1;
    endtask

    task automatic reset_now_check(input string name);
        #2;
        HRESETn = 1'b0;
        #1;
        check({name, "_grant"},   int'(HGRANT),   1);
        check({name, "_master"},  int'(HMASTER),  0);
        check({name, "_masterd"}, int'(HMASTERD), 0);
    endtask

    initial begin
        int           bleft;
        bit           prev_acc;
        logic [1:0]   tr;
        logic [2:0]   bu;
        logic         rdy;

        HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = 3'b000; HREADY = 1'b1;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_grant",   int'(HGRANT),   1);
        check("rst_master",  int'(HMASTER),  0);
        check("rst_masterd", int'(HMASTERD), 0);
        HRESETn = 1'b1;

        // Idle handover walks the requesters round-robin.
        cyc(4'b0110, '0, IDLE, 3'b000, 1'b1);
        check("idle_grant",  int'(HGRANT),  2);
        check("idle_master", int'(HMASTER), 1);
        cyc(4'b0110, '0, IDLE, 3'b000, 1'b1);
        check("idle_next_master", int'(HMASTER), 2);

        // INCR4 by master 1; master 3 must wait for the fourth beat.
        cyc(4'b0010, '0, IDLE, 3'b000, 1'b1);
        check("incr4_own", int'(HMASTER), 1);
        cyc(4'b1010, '0, NONSEQ, 3'b011, 1'b1);
        check("incr4_b1", int'(HMASTER), 1);
        cyc(4'b1010, '0, SEQ, 3'b011, 1'b1);
        check("incr4_b2", int'(HMASTER), 1);
        cyc(4'b1010, '0, SEQ, 3'b011, 1'b1);
        check("incr4_b3", int'(HMASTER), 1);
        cyc(4'b1010, '0, SEQ, 3'b011, 1'b1);
        check("incr4_hand",    int'(HMASTER),  3);
        check("incr4_hand_md", int'(HMASTERD), 1);

        // Same burst with two wait states on beat 2.
        cyc(4'b0010, '0, IDLE, 3'b000, 1'b1);
        check("wait_own", int'(HMASTER), 1);
        cyc(4'b1010, '0, NONSEQ, 3'b011, 1'b1);
        cyc(4'b1010, '0, SEQ, 3'b011, 1'b0);
        cyc(4'b1010, '0, SEQ, 3'b011, 1'b0);
        check("wait_hold",    int'(HMASTER),  1);
        check("wait_hold_md", int'(HMASTERD), 1);
        cyc(4'b1010, '0, SEQ, 3'b011, 1'b1);
        cyc(4'b1010, '0, SEQ, 3'b011, 1'b1);
        check("wait_b3", int'(HMASTER), 1);
        cyc(4'b1010, '0, SEQ, 3'b011, 1'b1);
        check("wait_hand",    int'(HMASTER),  3);
        check("wait_hand_md", int'(HMASTERD), 1);
        cyc(4'b1000, '0, IDLE, 3'b000, 1'b1);
        check("wait_after_md", int'(HMASTERD), 3);

        // No requesters parks on master 0.
        cyc(4'b0000, '0, IDLE, 3'b000, 1'b1);
        check("park_grant",  int'(HGRANT),  1);
        check("park_master", int'(HMASTER), 0);

        // Locked SINGLEs from master 2 with master 0 requesting.
        cyc(4'b0100, '0, IDLE, 3'b000, 1'b1);
        check("lock_own", int'(HMASTER), 2);
        cyc(4'b0101, 4'b0100, NONSEQ, 3'b000, 1'b1);
        check("lock_s1", int'(HMASTER), LOCK_EN ? 2 : 0);
        cyc(4'b0101, 4'b0100, NONSEQ, 3'b000, 1'b1);
        check("lock_s2", int'(HMASTER), 2);
        cyc(4'b0101, 4'b0000, IDLE, 3'b000, 1'b1);
        check("lock_rel", int'(HMASTER), 0);

        // Reset between edges in the middle of an INCR8.
        cyc(4'b0100, '0, NONSEQ, 3'b101, 1'b1);
        cyc(4'b0100, '0, SEQ, 3'b101, 1'b1);
        cyc(4'b0100, '0, SEQ, 3'b101, 1'b1);
        check("incr8_own", int'(HMASTER), 0);
        reset_now_check("rst_mid");
        cyc(4'b0100, '0, IDLE, 3'b000, 1'b1);
        HRESETn = 1'b1;
        cyc(4'b0100, '0, IDLE, 3'b000, 1'b1);
        check("rst_after", int'(HMASTER), 2);

        // Randomized burst traffic.
        bleft = 0; prev_acc = 1'b1; tr = IDLE; bu = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                reset_now_check("rst_rand");
                bleft = 0; prev_acc = 1'b1;
            end
            if (i == 1502) HRESETn = 1'b1;
            if (prev_acc) begin
                if ($urandom_range(0, 19) == 0) begin
                    tr = 2'($urandom); bu = 3'($urandom);
                end else if (bleft > 0) begin
                    if ($urandom_range(0, 7) == 0) tr = BUSY;
                    else begin tr = SEQ; bleft--; end
                end else if ($urandom_range(0, 3) == 0) begin
                    tr = IDLE;
                end else begin
                    tr = NONSEQ; bu = 3'($urandom);
                    bleft = (bu == 3'b001) ? int'($urandom_range(0, 6)) : beats_left(bu);
                end
            end
            rdy = ($urandom_range(0, 4) != 0);
            cyc(N'($urandom), N'($urandom), tr, bu, rdy);
            prev_acc = rdy;
        end

        @(negedge HCLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahb_bus_arbiter.md
AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting masters (2..8).
REQ-002 SHALL have parameter MIDX_W, default 3, width of master index outputs.
REQ-003 SHALL have port HCLK  input  1  bus clock; all state updates on rising edge.
REQ-004 SHALL have port HRESETn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port HBUSREQ  input  NUM_MASTERS  per-master bus request, level.
REQ-006 SHALL have port HLOCK  input  NUM_MASTERS  per-master locked-transfer request.
REQ-007 SHALL have port HTRANS  input  2  transfer type of current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 SHALL have port HBURST  input  3  burst type of current owner (000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16).
REQ-009 SHALL have port HREADY  input  1  bus ready; a phase completes when high.
REQ-010 SHALL have port HGRANT  output  NUM_MASTERS  one-hot address-phase grant, registered.
REQ-011 SHALL have port HMASTER  output  MIDX_W  index of HGRANT owner; drives HADDR/control mux select.
REQ-012 SHALL have port HMASTERD  output  MIDX_W  data-phase owner index; drives HWDATA mux select and HRDATA routing.

Function
REQ-013 HGRANT SHALL be exactly one-hot in every cycle out of reset.
REQ-014 Burst counter: on accepted NONSEQ (HREADY=1, HTRANS=10), SHALL load remaining beats = 0/3/7/15 for SINGLE/x4/x8/x16; INCR sets incr_open=1, counter 0.
REQ-015 On accepted SEQ, counter SHALL decrement; saturate at 0.
REQ-016 Accepted IDLE or NONSEQ SHALL clear incr_open before any reload; BUSY SHALL not change counter.
REQ-017 Arbitration point SHALL be a cycle with HREADY=1 and: HTRANS=IDLE; or NONSEQ with SINGLE; or SEQ with counter=1 and incr_open=0.
REQ-018 At an arbitration point the winner SHALL be the first requester round-robin from (HMASTER+1) mod NUM_MASTERS; current owner wins only if no other requester.
REQ-019 No requesters at an arbitration point SHALL park grant on master 0.
REQ-020 New grant SHALL appear on HGRANT/HMASTER the cycle after the arbitration point (1-cycle latency).
REQ-021 HMASTERD SHALL load HMASTER on each rising edge with HREADY=1; hold while HREADY=0.
REQ-022 Outside arbitration points HGRANT, HMASTER SHALL hold, regardless of HBUSREQ changes.
REQ-023 Owner dropping HBUSREQ mid-burst SHALL not end the burst; handover waits for REQ-017.
REQ-024 HREADY=0 SHALL freeze counter, incr_open, grant, HMASTERD.

Reset
REQ-025 HRESETn low SHALL asynchronously force HGRANT=1 (master 0), HMASTER=0, HMASTERD=0, counter=0, incr_open=0, lock=0.
REQ-026 Reset asserted mid-burst SHALL abandon the burst; first arbitration point after release uses priority from master 1.

Configuration
REQ-027 Macro AHB_ARB_LOCK_EN defined: lock flag SHALL register HLOCK[HMASTER] at each accepted NONSEQ; while set, arbitration points SHALL re-grant current owner; cleared at accepted IDLE/NONSEQ with HLOCK[HMASTER]=0.
REQ-028 Macro undefined: HLOCK SHALL be ignored, lock flag constant 0, behaviour per REQ-017..019 only.

Verification
REQ-029 HBUSREQ=4'b0110, owner 0, HTRANS=IDLE, HREADY=1 -> next cycle HGRANT=0010, HMASTER=1; next arbitration -> HMASTER=2.
REQ-030 Master 1 INCR4 (NONSEQ+3 SEQ), master 3 requests at beat 1 -> HMASTER=3 only the cycle after 4th beat accepted.
REQ-031 Same INCR4 with HREADY=0 two cycles on beat 2 -> handover delayed 2 cycles; HMASTERD tracks 1 until last data phase completes.
REQ-032 HBUSREQ=0 at arbitration point -> HGRANT=0001, HMASTER=0; one-hot check every cycle.
REQ-033 Assert HRESETn=0 mid-INCR8 between edges -> outputs immediately 0001/0/0; after release master 2 requesting wins first point.
REQ-034 With AHB_ARB_LOCK_EN, master 2 HLOCK=1 across two SINGLEs, master 0 requesting -> HMASTER stays 2 until IDLE with HLOCK=0; without macro, grant passes to 0 after first SINGLE.
